// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline sequencing controller for the 5-stage core
//
// Purpose: generates per-stage enable/flush pairs, EX-stage forwarding selects,
// a memory-wait FSM with timeout watchdog, and stall/flush performance counters.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   rs1_D, rs2_D                     ID-stage source registers
//   rs1_E, rs2_E                     EX-stage source registers
//   rd_E, reg_wr_en_E, is_load_E     EX-stage destination / write enable / load flag
//   redirect_E                       control-flow redirect resolved in EX
//   rd_M, reg_wr_en_M                ME-stage destination / write enable
//   lsu_req_M, lsu_ack               ME memory request and response valid
//   rd_W, reg_wr_en_W                WB-stage destination / write enable
//   enable_F..enable_W               stage advance enables
//   flush_D..flush_W                 bubble inserts (flush beats enable)
//   fwd_a_E, fwd_b_E                 00 regfile, 01 ME result, 10 WB result
//   mem_wait, mem_timeout, mem_err   wait state, forced-release pulse, sticky error
//   stall_cnt, flush_cnt             performance counters
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             reg_wr_en_E,
  input  logic             is_load_E,
  input  logic             redirect_E,
  input  logic [4:0]       rd_M,
  input  logic             reg_wr_en_M,
  input  logic             lsu_req_M,
  input  logic             lsu_ack,
  input  logic [4:0]       rd_W,
  input  logic             reg_wr_en_W,
  output logic             enable_F,
  output logic             enable_D,
  output logic             enable_E,
  output logic             enable_M,
  output logic             enable_W,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic             flush_W,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             mem_wait,
  output logic             mem_timeout,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       timeout_hit;
  logic       mem_stall;
  logic       load_use;
  logic       redirect_ok;

  // ME result beats WB result; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rdm, input logic wem,
                                         input logic [4:0] rdw, input logic wew);
    if (wem && (rdm != 5'd0) && (rdm == rs))      return 2'b01;
    else if (wew && (rdw != 5'd0) && (rdw == rs)) return 2'b10;
    else                                          return 2'b00;
  endfunction

  assign fwd_a_E  = fwd_sel(rs1_E, rd_M, reg_wr_en_M, rd_W, reg_wr_en_W);
  assign fwd_b_E  = fwd_sel(rs2_E, rd_M, reg_wr_en_M, rd_W, reg_wr_en_W);
  assign mem_wait = (state == MEM_WAIT);

  // FSM next state; the final no-ack wait cycle is treated as a forced ack.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_hit  = (state == MEM_WAIT) && !lsu_ack && (wait_cnt == TIMEOUT_LAST);
    mem_stall    = ((state == RUN) && lsu_req_M && !lsu_ack) ||
                   ((state == MEM_WAIT) && !lsu_ack && !timeout_hit);
    case (state)
      RUN: begin
        if (lsu_req_M && !lsu_ack) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (lsu_ack || timeout_hit) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Stage control by priority: memory stall, redirect, load-use, normal flow.
  always_comb begin
    enable_F    = 1'b1;
    enable_D    = 1'b1;
    enable_E    = 1'b1;
    enable_M    = 1'b1;
    enable_W    = 1'b1;
    flush_D     = 1'b0;
    flush_E     = 1'b0;
    flush_M     = 1'b0;
    flush_W     = 1'b0;
    redirect_ok = 1'b0;
    load_use    = is_load_E && reg_wr_en_E && (rd_E != 5'd0) &&
                  ((rd_E == rs1_D) || (rd_E == rs2_D));
    if (mem_stall) begin
      // EX is frozen, so redirect/load-use are re-evaluated after release.
      enable_F = 1'b0;
      enable_D = 1'b0;
      enable_E = 1'b0;
      enable_M = 1'b0;
      flush_W  = 1'b1;
    end else if (redirect_E) begin
      redirect_ok = 1'b1;
      flush_D     = 1'b1;
      flush_E     = 1'b1;
    end else if (load_use) begin
      enable_F = 1'b0;
      enable_D = 1'b0;
      flush_E  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
      mem_err     <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= timeout_hit;
      if (timeout_hit) mem_err <= 1'b1;
      if (!enable_D)   stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_ok) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It generates the per-stage `enable`/`flush` pairs consumed by the IF/ID, ID/EX, EX/ME and ME/WB pipeline registers, plus the EX-stage forwarding selects. It resolves four conditions:
- load-use hazards;
- control-flow redirects from EX;
- variable-latency data-memory accesses in ME, through a small wait FSM with a timeout watchdog;
- stall and flush performance counting.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: maximum cycles spent in MEM_WAIT before a forced release; legal range 1..255.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `rs1_D`, `rs2_D` in 5 each: source registers of the instruction in ID.
- `rs1_E`, `rs2_E` in 5 each: source registers of the instruction in EX.
- `rd_E` in 5, `reg_wr_en_E` in 1, `is_load_E` in 1: destination, write enable and load flag of the instruction in EX.
- `redirect_E` in 1: taken branch, jump or mispredict resolved in EX.
- `rd_M` in 5, `reg_wr_en_M` in 1: destination and write enable of the instruction in ME.
- `lsu_req_M` in 1: ME holds a load/store that needs a memory response.
- `lsu_ack` in 1: memory response valid this cycle.
- `rd_W` in 5, `reg_wr_en_W` in 1: destination and write enable of the instruction in WB.
- `enable_F`, `enable_D`, `enable_E`, `enable_M`, `enable_W` out 1 each: stage advance enables (PC, IF/ID, ID/EX, EX/ME, ME/WB).
- `flush_D`, `flush_E`, `flush_M`, `flush_W` out 1 each: bubble-insert signals. In every pipeline register, flush has priority over enable.
- `fwd_a_E`, `fwd_b_E` out 2 each: forwarding select. 00 = register file, 01 = ME ALU result, 10 = WB result.
- `mem_wait` out 1: FSM is in MEM_WAIT.
- `mem_timeout` out 1: one-cycle pulse on forced release.
- `mem_err` out 1: sticky flag, cleared only by reset.
- `stall_cnt` out `CNT_W`: count of cycles with `enable_D`=0.
- `flush_cnt` out `CNT_W`: count of cycles with `redirect_E` honoured.

## Operation
- FSM states: RUN and MEM_WAIT.
- Control and forwarding outputs are combinational functions of the state and the inputs. `mem_timeout`, `mem_err`, both counters and the wait counter are registered.

Priorities, highest first:
1. **Memory stall.** Condition: (RUN && `lsu_req_M` && !`lsu_ack`), or (MEM_WAIT && !`lsu_ack` && no timeout).
   - `enable_F`..`enable_M` = 0.
   - `enable_W` = 1 and `flush_W` = 1, so a bubble enters WB and there is no duplicate writeback.
   - All other flushes = 0. A `redirect_E` or load-use condition present in this cycle is ignored; it is re-evaluated on release because EX is frozen.
2. **Redirect** (`redirect_E`=1). `flush_D` = `flush_E` = 1 and all enables = 1.
3. **Load-use.** Condition: `is_load_E` && `reg_wr_en_E` && `rd_E`≠0 && (`rd_E`==`rs1_D` || `rd_E`==`rs2_D`).
   - `enable_F` = `enable_D` = 0.
   - `flush_E` = 1.
   - `enable_E`, `enable_M`, `enable_W` = 1.
4. **Otherwise.** All enables = 1, all flushes = 0.

Additional rules:
- `flush_M` is always 0. It is reserved and tied off.
- Forwarding for `fwd_a_E` (mirror with `rs2_E` for `fwd_b_E`):
  - 01 if `reg_wr_en_M` && `rd_M`≠0 && `rd_M`==`rs1_E`;
  - else 10 if `reg_wr_en_W` && `rd_W`≠0 && `rd_W`==`rs1_E`;
  - else 00.
  - ME beats WB.
  - Forwarding is evaluated in every state.

FSM transitions:
- RUN → MEM_WAIT when `lsu_req_M` && !`lsu_ack`. The wait counter is cleared to 0.
- MEM_WAIT → RUN on `lsu_ack`. That cycle behaves as priorities 2–4 (no memory stall).
- MEM_WAIT, no ack: the wait counter increments. When it equals `MEM_TIMEOUT`-1 and there is no ack:
  - `mem_timeout` pulses in the next cycle and `mem_err` is set;
  - the cycle is treated as an ack: the stage releases, the FSM goes to RUN and load data is undefined.
- `lsu_ack` while in RUN with no request is ignored.

Counters:
- Both counters wrap modulo 2^`CNT_W`.
- `stall_cnt` counts memory-stall and load-use cycles.
- `flush_cnt` counts only redirects honoured at priority 2.

## Timing
- **Reset values:** state = RUN, wait counter = 0, `mem_timeout` = 0, `mem_err` = 0, `stall_cnt` = 0, `flush_cnt` = 0, `mem_wait` = 0.
- **Control during reset:** with all inputs 0, the combinational outputs give every enable = 1, every flush = 0 and both `fwd_*` = 00.
- **Latency:** zero cycles for enables, flushes and forwarding. Registered state, counters and flags update on the next `posedge clk`.
- **Load-use:** costs exactly 1 bubble. On the next cycle the load is in ME, so the hazard clears and forwarding from WB covers it on the following cycle.
- **Memory wait:** an access acked N cycles after entering ME freezes F..M for N cycles and inserts N bubbles into WB.
- **Reset mid-wait:** asynchronous return to RUN. All counters and flags clear immediately.

## Test plan
- **Load-use.** `is_load_E`=1, `rd_E`=5, `rs2_D`=5 for one cycle → `enable_F`=`enable_D`=0, `flush_E`=1, `stall_cnt` 0→1. With `rd_E`=0 instead → no stall.
- **Redirect with load-use.** `redirect_E`=1 together with the load-use condition → `flush_D`=`flush_E`=1, all enables 1, `flush_cnt`=1, `stall_cnt` unchanged.
- **Memory wait.** `lsu_req_M`=1, `lsu_ack` asserted 3 cycles later → `mem_wait` high for 3 cycles, `flush_W`=1 for 3 cycles, `stall_cnt`=3. On the ack cycle all enables are 1.
- **Timeout.** `MEM_TIMEOUT`=4, `lsu_req_M`=1, no ack → after 4 stall cycles the pipeline releases, `mem_timeout` pulses 1 cycle, `mem_err` stays 1 until `rst_n`=0.
- **Forwarding.** `rs1_E`=7, `rd_M`=7 and `rd_W`=7, both write enables 1 → `fwd_a_E`=01. Drop `reg_wr_en_M` → 10. `rs1_E`=0 → 00.
- **Reset mid-wait.** `rst_n` pulsed low during MEM_WAIT → `mem_wait`=0 and counters 0 asynchronously. After release with `lsu_req_M`=0 → all enables 1.
